// File: rtl/user_stream_tx_if.sv
// Push-side and operator-side handshake bundle for user_stream_tx.
// master = the transmitter block, slave = its environment (receive path + operator).
interface user_stream_tx_if #(
  parameter int PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] din_leaf_bft2user;
  logic                    din_vld;
  logic                    din_rdy;
  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;

  modport master (
    input  din_leaf_bft2user, din_vld, ack_user2interface,
    output din_rdy, dout_leaf_interface2user, vld_interface2user
  );

  modport slave (
    output din_leaf_bft2user, din_vld, ack_user2interface,
    input  din_rdy, dout_leaf_interface2user, vld_interface2user
  );
endinterface

// File: rtl/user_stream_tx.sv
// ap_vld/ap_ack user-stream transmitter: FIFO + output register, freespace credit pulses.
// Define USER_STREAM_TX_STATS_EN to add saturating transfer/stall counters.
module user_stream_tx #(
  parameter int PAYLOAD_BITS          = 32,
  parameter int FIFO_ADDR_BITS        = 4,
  parameter int FREESPACE_UPDATE_SIZE = 8
) (
  input  logic                      clk_user,
  input  logic                      reset,
  user_stream_tx_if.master          bus,
  output logic                      freespace_upd,
  output logic [FIFO_ADDR_BITS+1:0] occupancy
`ifdef USER_STREAM_TX_STATS_EN
  ,
  output logic [31:0]               stat_xfer_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  localparam int DEPTH = 2 ** FIFO_ADDR_BITS;
  localparam int OCC_W = FIFO_ADDR_BITS + 2;
  localparam int FC_W  = FIFO_ADDR_BITS + 1;
  localparam int CNT_W = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam logic [OCC_W-1:0] CAP     = OCC_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(FREESPACE_UPDATE_SIZE - 1);

  typedef enum logic {OREG_EMPTY, OREG_FULL} oreg_state_e;

  oreg_state_e state_q, state_d;

  logic [PAYLOAD_BITS-1:0]   mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FC_W-1:0]           fifo_cnt;
  logic [PAYLOAD_BITS-1:0]   oreg;
  logic [CNT_W-1:0]          cons_cnt;
  logic push, pop, fifo_wr, fifo_rd, load_fifo, load_bypass, fifo_nempty;

  // Ready looks only at occupancy, so a full block never admits a push even on a pop cycle.
  assign bus.din_rdy                  = reset && (occupancy < CAP);
  assign bus.vld_interface2user       = (state_q == OREG_FULL);
  assign bus.dout_leaf_interface2user = oreg;

  assign push        = bus.din_vld && bus.din_rdy;
  assign pop         = bus.vld_interface2user && bus.ack_user2interface;
  assign fifo_nempty = (fifo_cnt != '0);
  assign fifo_rd     = load_fifo;
  assign fifo_wr     = push && !load_bypass;

  // OREG refill: FIFO head has priority; an incoming word bypasses only when the FIFO is dry.
  always_comb begin
    state_d     = state_q;
    load_fifo   = 1'b0;
    load_bypass = 1'b0;
    case (state_q)
      OREG_EMPTY: begin
        if (fifo_nempty) begin
          load_fifo = 1'b1;
          state_d   = OREG_FULL;
        end else if (push) begin
          load_bypass = 1'b1;
          state_d     = OREG_FULL;
        end
      end
      OREG_FULL: begin
        if (pop) begin
          if (fifo_nempty)  load_fifo   = 1'b1;
          else if (push)    load_bypass = 1'b1;
          else              state_d     = OREG_EMPTY;
        end
      end
      default: state_d = OREG_EMPTY;
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (!reset) begin
      state_q       <= OREG_EMPTY;
      oreg          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      occupancy     <= '0;
      cons_cnt      <= '0;
      freespace_upd <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_fifo)        oreg <= mem[rd_ptr];
      else if (load_bypass) oreg <= bus.din_leaf_bft2user;
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt  <= fifo_cnt + FC_W'(fifo_wr) - FC_W'(fifo_rd);
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
      freespace_upd <= 1'b0;
      if (pop) begin
        if (cons_cnt == FS_LAST) begin
          cons_cnt      <= '0;
          freespace_upd <= 1'b1;
        end else begin
          cons_cnt <= cons_cnt + 1'b1;
        end
      end
    end
  end

  // Storage array is not reset; pointers/count make stale entries unreachable.
  always_ff @(posedge clk_user) begin
    if (fifo_wr) mem[wr_ptr] <= bus.din_leaf_bft2user;
  end

`ifdef USER_STREAM_TX_STATS_EN
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      stat_xfer_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (pop && (stat_xfer_cnt != '1))
        stat_xfer_cnt <= stat_xfer_cnt + 1'b1;
      if (bus.vld_interface2user && !bus.ack_user2interface && (stat_stall_cnt != '1))
        stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_user_stream_tx.sv
// Self-checking bench for user_stream_tx: vector table, directed corner sequences,
// and random backpressure against a queue-based model of the buffer.
module tb_user_stream_tx;
  localparam int PB  = 32;
  localparam int AB  = 4;
  localparam int FS  = 8;
  localparam int CAP = 17;

  logic          clk_user = 1'b0;
  logic          reset;
  logic          freespace_upd;
  logic [AB+1:0] occupancy;
`ifdef USER_STREAM_TX_STATS_EN
  logic [31:0]   stat_xfer_cnt, stat_stall_cnt;
`endif

  user_stream_tx_if #(.PAYLOAD_BITS(PB)) bus ();

  user_stream_tx #(
    .PAYLOAD_BITS(PB), .FIFO_ADDR_BITS(AB), .FREESPACE_UPDATE_SIZE(FS)
  ) dut (
    .clk_user(clk_user),
    .reset(reset),
    .bus(bus),
    .freespace_upd(freespace_upd),
    .occupancy(occupancy)
`ifdef USER_STREAM_TX_STATS_EN
    ,
    .stat_xfer_cnt(stat_xfer_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk_user = ~clk_user;

  int checks   = 0;
  int failures = 0;

  // Reference: the block is a FIFO of capacity CAP whose head is shown on dout.
  logic [PB-1:0] mq[$];
  int  consumed, xfers, stalls;
  bit  fs_exp;

  typedef struct {
    bit          rst;
    bit          dv;
    logic [31:0] d;
    bit          ack;
    bit          e_vld;
    bit          chk_d;
    logic [31:0] e_dout;
    int          e_occ;
    bit          e_rdy;
    bit          e_fs;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance the model, check post-edge outputs.
  task automatic step(input bit rv, input bit dv, input logic [PB-1:0] d, input bit ack);
    bit p_pop, p_push, rdy;
    reset                     = rv;
    bus.din_vld               = dv;
    bus.din_leaf_bft2user     = d;
    bus.ack_user2interface    = ack;
    #1;
    rdy = rv && (mq.size() < CAP);
    chk("din_rdy", {63'd0, bus.din_rdy}, {63'd0, rdy});
    p_pop  = (mq.size() > 0) && ack;
    p_push = dv && rdy;
    fs_exp = 1'b0;
    if (!rv) begin
      mq.delete();
      consumed = 0;
      xfers    = 0;
      stalls   = 0;
    end else begin
      if (mq.size() > 0 && !ack) stalls++;
      if (p_pop) begin
        void'(mq.pop_front());
        consumed++;
        xfers++;
        fs_exp = (consumed % FS == 0);
      end
      if (p_push) mq.push_back(d);
    end
    @(posedge clk_user);
    #1;
    chk("vld", {63'd0, bus.vld_interface2user}, {63'd0, mq.size() > 0});
    if (mq.size() > 0) chk("dout", 64'(bus.dout_leaf_interface2user), 64'(mq[0]));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("freespace_upd", {63'd0, freespace_upd}, {63'd0, fs_exp});
`ifdef USER_STREAM_TX_STATS_EN
    chk("stat_xfer_cnt", 64'(stat_xfer_cnt), 64'(xfers));
    chk("stat_stall_cnt", 64'(stat_stall_cnt), 64'(stalls));
`endif
  endtask

  initial begin
    int fs_cnt;
    reset                  = 1'b0;
    bus.din_vld            = 1'b0;
    bus.din_leaf_bft2user  = '0;
    bus.ack_user2interface = 1'b0;
    consumed = 0; xfers = 0; stalls = 0; fs_exp = 1'b0;

    // Reset with push attempted, bypass load, 5-cycle hold, single ack, stray ack.
    tbl[0]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1, 1'b1, 1'b0};
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].dv, tbl[i].d, tbl[i].ack);
      chk("tbl_vld", {63'd0, bus.vld_interface2user}, {63'd0, tbl[i].e_vld});
      if (tbl[i].chk_d) chk("tbl_dout", 64'(bus.dout_leaf_interface2user), 64'(tbl[i].e_dout));
      chk("tbl_occ", 64'(occupancy), 64'(tbl[i].e_occ));
      chk("tbl_rdy", {63'd0, bus.din_rdy}, {63'd0, tbl[i].e_rdy});
      chk("tbl_fs", {63'd0, freespace_upd}, {63'd0, tbl[i].e_fs});
    end

    // Fill to capacity, then pop while pushing into a full block.
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
    chk("fill_occ", 64'(occupancy), 64'd17);
    chk("fill_rdy", {63'd0, bus.din_rdy}, 64'd0);
    chk("fill_head", 64'(bus.dout_leaf_interface2user), 64'd0);
    step(1'b1, 1'b1, 32'h99, 1'b1);
    chk("fill_pop_occ", 64'(occupancy), 64'd16);
    chk("fill_pop_dout", 64'(bus.dout_leaf_interface2user), 64'd1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("drain_vld", {63'd0, bus.vld_interface2user}, 64'd0);
    chk("drain_occ", 64'(occupancy), 64'd0);

    // Sustained streaming with freespace pulses every 8 pops.
    step(1'b0, 1'b0, '0, 1'b0);
    fs_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 32'(1000 + i), 1'b1);
      chk("stream_dout", 64'(bus.dout_leaf_interface2user), 64'(1000 + i));
      chk("stream_occ", 64'(occupancy), 64'd1);
      chk("fs_pulse", {63'd0, freespace_upd}, {63'd0, (i > 0) && (i % 8 == 0)});
      if (freespace_upd) fs_cnt++;
      if (i == 24) chk("fs_count24", 64'(fs_cnt), 64'd3);
    end
    chk("fs_count100", 64'(fs_cnt), 64'd12);

    // Random backpressure against the model.
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      bit dv, ak;
      dv = 1'($urandom_range(0, 1));
      ak = 1'($urandom_range(0, 1));
      step(1'b1, dv, $urandom, ak);
    end

    // Mid-operation reset discards buffered words, then drain check on a fresh stream.
    step(1'b1, 1'b1, 32'h1234, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_vld", {63'd0, bus.vld_interface2user}, 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'(2000 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("final_occ", 64'(occupancy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
